// File: rtl/riscv_pkg.sv
// Shared types and funct3 decode for the load/store unit.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Access size in bytes from funct3[1:0]: 1, 2, 4 or 8.
  function automatic logic [3:0] size_bytes(input logic [1:0] size_log2);
    return 4'd1 << size_log2;
  endfunction

  // Unsigned variants exist only for loads; 3'b111 is never legal.
  function automatic logic f3_illegal(input logic we, input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_H, F3_W, F3_D: return 1'b0;
      F3_BU, F3_HU, F3_WU:    return we;
      default:                return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Lane alignment for both beats: byte enables, store data shift and load right-justify.
module riscv_lsu_align
  import riscv_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int NBYTES = XLEN / 8
) (
  input  logic [2:0]        i_off,
  input  logic [1:0]        i_size_log2,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic [XLEN-1:0]   i_buf0,
  input  logic [XLEN-1:0]   i_buf1,
  output logic              o_split,
  output logic [NBYTES-1:0] o_be0,
  output logic [NBYTES-1:0] o_be1,
  output logic [XLEN-1:0]   o_wdata0,
  output logic [XLEN-1:0]   o_wdata1,
  output logic [XLEN-1:0]   o_rdata
);

  logic [3:0]          w_size;
  logic [4:0]          w_end;
  logic [2*NBYTES-1:0] w_m16;
  logic [2*XLEN-1:0]   w_w128;
  logic [5:0]          w_bit_off;

  assign w_size    = size_bytes(i_size_log2);
  assign w_end     = {2'b00, i_off} + {1'b0, w_size};
  assign o_split   = (w_end > 5'd8);
  assign w_bit_off = {i_off, 3'b000};

  assign w_m16 = ((2*NBYTES)'(1) << w_size) - (2*NBYTES)'(1) << i_off;
  assign o_be0 = w_m16[NBYTES-1:0];
  assign o_be1 = w_m16[2*NBYTES-1:NBYTES];

  assign w_w128   = {{XLEN{1'b0}}, i_wdata} << w_bit_off;
  assign o_wdata0 = w_w128[XLEN-1:0];
  assign o_wdata1 = w_w128[2*XLEN-1:XLEN];

  // buf1 is cleared on accept, so unsplit loads shift in zeros from above.
  assign o_rdata = XLEN'({i_buf1, i_buf0} >> w_bit_off);

endmodule

// File: rtl/riscv_lsu_ctrl.sv
// Load/store sequencer: one request at a time, split into two doubleword beats when it straddles 8 bytes.
module riscv_lsu_ctrl
  import riscv_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int NBYTES = XLEN / 8
) (
  input  logic              i_riscv_clk,
  input  logic              i_riscv_rst_n,
  input  logic              i_riscv_lsu_valid,
  output logic              o_riscv_lsu_ready,
  input  logic              i_riscv_lsu_we,
  input  logic [2:0]        i_riscv_lsu_funct3,
  input  logic [XLEN-1:0]   i_riscv_lsu_addr,
  input  logic [XLEN-1:0]   i_riscv_lsu_wdata,
  output logic              o_riscv_lsu_done,
  output logic              o_riscv_lsu_err,
  output logic [XLEN-1:0]   o_riscv_lsu_rdata,
  output logic [2:0]        o_riscv_lsu_memext_sel,
  output logic              o_riscv_mem_req,
  output logic              o_riscv_mem_we,
  output logic [XLEN-1:0]   o_riscv_mem_addr,
  output logic [NBYTES-1:0] o_riscv_mem_be,
  output logic [XLEN-1:0]   o_riscv_mem_wdata,
  input  logic              i_riscv_mem_gnt,
  input  logic              i_riscv_mem_rvalid,
  input  logic [XLEN-1:0]   i_riscv_mem_rdata
);

  lsu_state_e r_state;
  lsu_state_e w_next;

  logic            r_we;
  logic            r_err;
  logic            r_beat;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_buf0;
  logic [XLEN-1:0] r_buf1;

  logic              w_accept;
  logic              w_illegal;
  logic              w_split;
  logic [NBYTES-1:0] w_be0;
  logic [NBYTES-1:0] w_be1;
  logic [XLEN-1:0]   w_wdata0;
  logic [XLEN-1:0]   w_wdata1;
  logic [XLEN-1:0]   w_rdata;

  assign w_accept  = (r_state == IDLE) && i_riscv_lsu_valid;
  assign w_illegal = f3_illegal(i_riscv_lsu_we, i_riscv_lsu_funct3);

  riscv_lsu_align #(
    .XLEN   (XLEN),
    .NBYTES (NBYTES)
  ) u_align (
    .i_off       (r_addr[2:0]),
    .i_size_log2 (r_funct3[1:0]),
    .i_wdata     (r_wdata),
    .i_buf0      (r_buf0),
    .i_buf1      (r_buf1),
    .o_split     (w_split),
    .o_be0       (w_be0),
    .o_be1       (w_be1),
    .o_wdata0    (w_wdata0),
    .o_wdata1    (w_wdata1),
    .o_rdata     (w_rdata)
  );

  // NOTE: state and datapath registers use non-blocking assignments so every
  // read in this block sees the pre-edge value regardless of statement order.
  always_ff @(posedge i_riscv_clk) begin
    if (!i_riscv_rst_n) begin
      r_state  <= IDLE;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_beat   <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_buf0   <= '0;
      r_buf1   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we     <= i_riscv_lsu_we;
        r_err    <= w_illegal;
        r_beat   <= 1'b0;
        r_funct3 <= i_riscv_lsu_funct3;
        r_addr   <= i_riscv_lsu_addr;
        r_wdata  <= i_riscv_lsu_wdata;
        r_buf0   <= '0;
        r_buf1   <= '0;
      end
      if ((r_state == RESP) && i_riscv_mem_rvalid) begin
        if (r_beat) r_buf1 <= i_riscv_mem_rdata;
        else        r_buf0 <= i_riscv_mem_rdata;
        if (w_split && !r_beat) r_beat <= 1'b1;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_next            = r_state;
    o_riscv_lsu_ready = 1'b0;
    o_riscv_lsu_done  = 1'b0;
    o_riscv_lsu_err   = 1'b0;
    o_riscv_mem_req   = 1'b0;
    o_riscv_mem_we    = 1'b0;
    o_riscv_mem_be    = '0;
    case (r_state)
      IDLE: begin
        o_riscv_lsu_ready = 1'b1;
        if (i_riscv_lsu_valid) w_next = w_illegal ? DONE : REQ;
      end
      REQ: begin
        o_riscv_mem_req = 1'b1;
        o_riscv_mem_we  = r_we;
        o_riscv_mem_be  = r_beat ? w_be1 : w_be0;
        if (i_riscv_mem_gnt) w_next = RESP;
      end
      RESP: begin
        if (i_riscv_mem_rvalid) w_next = (w_split && !r_beat) ? REQ : DONE;
      end
      DONE: begin
        o_riscv_lsu_done = 1'b1;
        o_riscv_lsu_err  = r_err;
        w_next           = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Beat 1 is the next doubleword; the add wraps naturally at 2^XLEN.
  assign o_riscv_mem_addr       = {r_addr[XLEN-1:3], 3'b000} + XLEN'({r_beat, 3'b000});
  assign o_riscv_mem_wdata      = r_beat ? w_wdata1 : w_wdata0;
  assign o_riscv_lsu_rdata      = w_rdata;
  assign o_riscv_lsu_memext_sel = r_funct3;

endmodule
